relay_rx_deframer: RTL and testbench

- Receive-side deframer for the relay link. Samples the serial relay input (dbg pin) at ck_1356meg/16 and detects start/end-of-communication patterns.
- Produces the effective 3-bit modulation type for hi_iso14443a, plus a delayed data bit that replaces ssp_dout while a relay mode is active.
- Sits between the dbg pad and the hisn mod_type/ssp_dout inputs in the top level.

---
 rtl/relay_rx_deframer.sv | 213 +++++++++++++++++++++
 tb/tb_relay_rx_deframer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/relay_rx_deframer.sv
// relay_rx_deframer
//   Receive-side deframer for the relay link. The raw relay line (dbg pad)
//   is synchronised and sampled once every 2^DIV_W clocks while a relay mode
//   (FAKE_READER / FAKE_TAG) is configured. A 24-bit sample history is
//   matched against start/end-of-communication patterns to switch the
//   effective hi_iso14443a modulation type between its MOD and LISTEN
//   values. Outside relay modes the configured mode passes straight through.
//
//   Optional feature: define RELAY_RX_TIMEOUT_EN to abort frames that run
//   for MAX_FRAME_BYTES bytes without an end pattern (frame_err pulses).
//   With the macro undefined, frame_err is tied low and frames never time out.
//
// Ports
//   ck_1356meg    in   13.56 MHz clock, rising edge
//   nrst          in   async active-low reset
//   mode[2:0]     in   configured hi_simulate_mod_type
//   rx_in         in   raw relay serial line, asynchronous
//   mod_type[2:0] out  effective modulation type
//   data_bit      out  delayed relay data bit (hist[7])
//   data_valid    out  one-cycle pulse per sample inside a frame
//   frame_active  out  high while a frame is open
//   frame_err     out  one-cycle pulse on timeout abort
module relay_rx_deframer #(
    parameter int DIV_W           = 4,
    parameter int SAMPLE_PHASE    = 8,
    parameter int MAX_FRAME_BYTES = 64
) (
    input  logic       ck_1356meg,
    input  logic       nrst,
    input  logic [2:0] mode,
    input  logic       rx_in,
    output logic [2:0] mod_type,
    output logic       data_bit,
    output logic       data_valid,
    output logic       frame_active,
    output logic       frame_err
);

    localparam logic [2:0] TAGSIM_LISTEN = 3'd1;
    localparam logic [2:0] TAGSIM_MOD    = 3'd2;
    localparam logic [2:0] READER_LISTEN = 3'd3;
    localparam logic [2:0] READER_MOD    = 3'd4;
    localparam logic [2:0] FAKE_READER   = 3'd5;
    localparam logic [2:0] FAKE_TAG      = 3'd6;

    localparam logic [DIV_W-1:0] PHASE = DIV_W'(SAMPLE_PHASE);

    // The byte counter is 7 bits wide.
    if (MAX_FRAME_BYTES < 1 || MAX_FRAME_BYTES > 127) begin : g_bad_max
        $error("MAX_FRAME_BYTES must be in 1..127");
    end

    typedef enum logic {IDLE, FRAME} state_t;

    logic             rx_meta_q, rx_meta_d;
    logic             rx_s_q, rx_s_d;
    logic [2:0]       mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [23:0]      hist_q, hist_d;
    logic [2:0]       cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [2:0]       relay_mod_q, relay_mod_d;
    logic [2:0]       mod_type_q, mod_type_d;
    logic             data_bit_q, data_bit_d;
    logic             data_valid_q, data_valid_d;

    logic             relay, mode_chg, strobe;
    logic             start_hit, end_hit;
    logic [23:0]      hist_n;
    logic [2:0]       cnt_n;
    logic [2:0]       listen_val, mod_val;

`ifdef RELAY_RX_TIMEOUT_EN
    logic [6:0]       byte_cnt_q, byte_cnt_d;
    logic [6:0]       byte_inc;
    logic             frame_err_q, frame_err_d;
`endif

    always_comb begin
        rx_meta_d  = rx_in;
        rx_s_d     = rx_meta_q;
        mode_d     = mode;

        relay      = (mode == FAKE_READER) || (mode == FAKE_TAG);
        mode_chg   = (mode != mode_q);
        listen_val = (mode == FAKE_TAG) ? TAGSIM_LISTEN : READER_LISTEN;
        mod_val    = (mode == FAKE_TAG) ? TAGSIM_MOD    : READER_MOD;
        // A sample taken in the mode-change cycle would belong to the old
        // mode, so it is suppressed.
        strobe     = relay && !mode_chg && (div_q == PHASE);

        hist_n     = {hist_q[22:0], rx_s_q};
        cnt_n      = cnt_q + 3'd1;

        start_hit  = 1'b0;
        end_hit    = 1'b0;
        case (mode)
            FAKE_READER: begin
                start_hit = (hist_n == 24'h0000C0);
                end_hit   = (hist_n[23:8] == 16'h0000) || (hist_n[23:8] == 16'hC000);
            end
            FAKE_TAG: begin
                start_hit = (hist_n == 24'h0000F0);
                end_hit   = (hist_n[15:8] == 8'h00);
            end
            default: ;
        endcase

        div_d        = div_q + DIV_W'(1);
        hist_d       = hist_q;
        cnt_d        = cnt_q;
        state_d      = state_q;
        relay_mod_d  = relay_mod_q;
        data_bit_d   = data_bit_q;
        data_valid_d = 1'b0;
`ifdef RELAY_RX_TIMEOUT_EN
        byte_cnt_d   = byte_cnt_q;
        byte_inc     = byte_cnt_q + 7'd1;
        frame_err_d  = 1'b0;
`endif

        if (mode_chg) begin
            div_d       = '0;
            hist_d      = '0;
            cnt_d       = '0;
            state_d     = IDLE;
            relay_mod_d = relay ? listen_val : 3'd0;
`ifdef RELAY_RX_TIMEOUT_EN
            byte_cnt_d  = '0;
`endif
        end else if (strobe) begin
            hist_d     = hist_n;
            cnt_d      = cnt_n;
            data_bit_d = hist_n[7];
            if (start_hit) begin
                // Start wins over end and re-aligns bytes even mid-frame.
                cnt_d       = '0;
                state_d     = FRAME;
                relay_mod_d = mod_val;
`ifdef RELAY_RX_TIMEOUT_EN
                byte_cnt_d  = '0;
`endif
            end else if (state_q == FRAME && cnt_n == 3'd0) begin
                // End patterns only count on a byte boundary.
                if (end_hit) begin
                    state_d     = IDLE;
                    relay_mod_d = listen_val;
                end
`ifdef RELAY_RX_TIMEOUT_EN
                else if (byte_inc == 7'(MAX_FRAME_BYTES)) begin
                    state_d     = IDLE;
                    relay_mod_d = listen_val;
                    frame_err_d = 1'b1;
                end else begin
                    byte_cnt_d  = byte_inc;
                end
`endif
            end
            data_valid_d = (state_d == FRAME);
        end

        mod_type_d = relay ? relay_mod_d : mode;
    end

    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            rx_meta_q    <= 1'b0;
            rx_s_q       <= 1'b0;
            mode_q       <= '0;
            div_q        <= '0;
            hist_q       <= '0;
            cnt_q        <= '0;
            state_q      <= IDLE;
            relay_mod_q  <= '0;
            mod_type_q   <= '0;
            data_bit_q   <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            mode_q       <= mode_d;
            div_q        <= div_d;
            hist_q       <= hist_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            relay_mod_q  <= relay_mod_d;
            mod_type_q   <= mod_type_d;
            data_bit_q   <= data_bit_d;
            data_valid_q <= data_valid_d;
        end
    end

`ifdef RELAY_RX_TIMEOUT_EN
    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            byte_cnt_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign mod_type     = mod_type_q;
    assign data_bit     = data_bit_q;
    assign data_valid   = data_valid_q;
    assign frame_active = (state_q == FRAME);

endmodule

// File: tb/tb_relay_rx_deframer.sv
// Directed bench for relay_rx_deframer. Each relay bit is held for one full
// 16-clock sample period starting just after the edge that realigns the
// divider, so every bit is sampled exactly once.
module tb_relay_rx_deframer;

    logic       ck_1356meg = 1'b0;
    logic       nrst;
    logic [2:0] mode;
    logic       rx_in;
    logic [2:0] mod_type;
    logic       data_bit;
    logic       data_valid;
    logic       frame_active;
    logic       frame_err;

    int n_chk = 0;
    int n_err = 0;
    int dv_cnt = 0;
    int err_cnt = 0;
    int base;

    relay_rx_deframer #(
        .DIV_W          (4),
        .SAMPLE_PHASE   (8),
        .MAX_FRAME_BYTES(2)
    ) dut (
        .ck_1356meg  (ck_1356meg),
        .nrst        (nrst),
        .mode        (mode),
        .rx_in       (rx_in),
        .mod_type    (mod_type),
        .data_bit    (data_bit),
        .data_valid  (data_valid),
        .frame_active(frame_active),
        .frame_err   (frame_err)
    );

    always #5 ck_1356meg = ~ck_1356meg;

    always @(negedge ck_1356meg) begin
        if (data_valid) dv_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_mode(input logic [2:0] m);
        mode = m;
        @(posedge ck_1356meg);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (16) @(posedge ck_1356meg);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    initial begin
        nrst  = 1'b0;
        mode  = 3'd3;
        rx_in = 1'b0;
        #23;
        chk("rst_mod_type", 32'(mod_type), 32'd0);
        chk("rst_active",   32'(frame_active), 32'd0);
        chk("rst_dv",       32'(data_valid), 32'd0);
        chk("rst_bit",      32'(data_bit), 32'd0);
        chk("rst_err",      32'(frame_err), 32'd0);
        nrst = 1'b1;
        @(posedge ck_1356meg);
        #1;
        chk("pass_mod_type", 32'(mod_type), 32'd3);
        chk("pass_active",   32'(frame_active), 32'd0);
        base = dv_cnt;
        repeat (64) @(posedge ck_1356meg);
        #1;
        chk("pass_no_dv", 32'(dv_cnt - base), 32'd0);

        // FAKE_READER start / end
        set_mode(3'd5);
        chk("rd_listen", 32'(mod_type), 32'd3);
        send_zeros(16);
        send_bit(1'b1); send_bit(1'b1);
        send_zeros(5);
        chk("rd_pre_start", 32'(mod_type), 32'd3);
        chk("rd_pre_active", 32'(frame_active), 32'd0);
        base = dv_cnt;
        send_bit(1'b0);
        chk("rd_start_mod", 32'(mod_type), 32'd4);
        chk("rd_start_active", 32'(frame_active), 32'd1);
        chk("rd_start_dv", 32'(dv_cnt - base), 32'd1);
        send_zeros(8);
        chk("rd_byte1_stay", 32'(mod_type), 32'd4);
        send_zeros(8);
        chk("rd_end_mod", 32'(mod_type), 32'd3);
        chk("rd_end_active", 32'(frame_active), 32'd0);
        chk("rd_dv_total", 32'(dv_cnt - base), 32'd16);

        // FAKE_TAG start / end, data_bit delay
        set_mode(3'd6);
        chk("tg_listen", 32'(mod_type), 32'd1);
        send_zeros(16);
        send_byte(8'hF0);
        chk("tg_start_mod", 32'(mod_type), 32'd2);
        chk("tg_start_active", 32'(frame_active), 32'd1);
        chk("tg_bit_1", 32'(data_bit), 32'd1);
        base = dv_cnt;
        send_zeros(4);
        chk("tg_bit_0", 32'(data_bit), 32'd0);
        send_zeros(4);
        chk("tg_s8_stay", 32'(mod_type), 32'd2);
        send_zeros(4);
        chk("tg_s12_nonbound", 32'(mod_type), 32'd2);
        send_zeros(4);
        chk("tg_end_mod", 32'(mod_type), 32'd1);
        chk("tg_end_active", 32'(frame_active), 32'd0);
        chk("tg_dv_total", 32'(dv_cnt - base), 32'd15);

        // Mode change mid-frame
        set_mode(3'd5);
        send_zeros(16);
        send_byte(8'hC0);
        chk("mc_rd_active", 32'(frame_active), 32'd1);
        set_mode(3'd6);
        chk("mc_active", 32'(frame_active), 32'd0);
        chk("mc_mod_type", 32'(mod_type), 32'd1);
        send_byte(8'hF0);
        chk("mc_hist_clear", 32'(mod_type), 32'd2);

        // Async reset mid-frame
        #3;
        nrst = 1'b0;
        #1;
        chk("ar_mod_type", 32'(mod_type), 32'd0);
        chk("ar_active",   32'(frame_active), 32'd0);
        chk("ar_bit",      32'(data_bit), 32'd0);
        chk("ar_dv",       32'(data_valid), 32'd0);
        #2;
        nrst = 1'b1;
        @(posedge ck_1356meg);
        #1;
        chk("ar_relisten", 32'(mod_type), 32'd1);

        // Leave relay mode
        set_mode(3'd3);
        chk("lv_mod_type", 32'(mod_type), 32'd3);
        base = dv_cnt;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        chk("lv_no_dv", 32'(dv_cnt - base), 32'd0);
        chk("lv_active", 32'(frame_active), 32'd0);

        // Long frame: timeout with the feature, open-ended without
        set_mode(3'd5);
        send_zeros(16);
        send_byte(8'hC0);
        chk("to_start", 32'(frame_active), 32'd1);
        base = err_cnt;
        send_byte(8'hFF);
        chk("to_byte1", 32'(frame_active), 32'd1);
        send_byte(8'hFF);
`ifdef RELAY_RX_TIMEOUT_EN
        chk("to_err", 32'(err_cnt - base), 32'd1);
        chk("to_mod_type", 32'(mod_type), 32'd3);
        chk("to_active", 32'(frame_active), 32'd0);
`else
        chk("to_err", 32'(err_cnt - base), 32'd0);
        chk("to_mod_type", 32'(mod_type), 32'd4);
        chk("to_active", 32'(frame_active), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
